// File: rtl/led_pattern_gen.sv
// LED pattern generator for board bring-up and status display.
// A programmable prescaler produces a step tick; each tick advances the pattern
// register according to the selected mode (rotate left, rotate right, bounce,
// binary count). Mode changes and loads restart the pattern and the prescaler.
//
// Ports:
//   clk      - clock
//   rst      - asynchronous active-high reset
//   enable   - 1: prescaler runs; 0: prescaler and pattern frozen
//   mode     - 00 rotate left, 01 rotate right, 10 bounce, 11 binary count
//   div      - step period minus one (step every div+1 enabled cycles)
//   load     - synchronous preload strobe
//   load_val - preload value for the pattern
//   led      - pattern after polarity
//   step     - one-cycle pulse, high in the first cycle a new pattern is visible
//   wrap     - one-cycle pulse marking the end of a full pattern period
//   cnt_out  - current prescaler count
module led_pattern_gen #(
  parameter int unsigned      WIDTH      = 8,
  parameter int unsigned      PRESCALE_W = 24,
  parameter logic [WIDTH-1:0] INIT       = WIDTH'(1),
  parameter bit               ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [1:0]            mode,
  input  logic [PRESCALE_W-1:0] div,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  output logic [WIDTH-1:0]      led,
  output logic                  step,
  output logic                  wrap,
  output logic [PRESCALE_W-1:0] cnt_out
);

  localparam int unsigned PosW = $clog2(WIDTH);
  localparam logic [PosW-1:0] PosLast   = PosW'(WIDTH - 1);
  localparam logic [PosW-1:0] PosPenult = PosW'(WIDTH - 2);
  localparam logic [WIDTH-1:0] OneHot0  = WIDTH'(1);

  typedef enum logic [1:0] {ModeRotL, ModeRotR, ModeBounce, ModeCount} mode_e;
  typedef enum logic {DirUp, DirDown} dir_e;

  logic [PRESCALE_W-1:0] cnt_q;
  logic [WIDTH-1:0]      pat_q;
  logic [PosW-1:0]       pos_q;
  logic [PosW-1:0]       nsteps_q;
  dir_e                  dir_q;
  logic [1:0]            mode_q;
  logic                  step_q;
  logic                  wrap_q;

  // Next pattern state, applied only when a tick is taken.
  logic [WIDTH-1:0] pat_step;
  logic [PosW-1:0]  pos_step;
  logic [PosW-1:0]  nsteps_step;
  dir_e             dir_step;
  logic             wrap_step;
  logic             tick;

  // >= rather than == so lowering div below the current count ends the period
  // on the next enabled cycle instead of waiting for a counter wrap.
  assign tick = enable && (cnt_q >= div);

  always_comb begin
    pat_step    = pat_q;
    pos_step    = pos_q;
    nsteps_step = nsteps_q;
    dir_step    = dir_q;
    wrap_step   = 1'b0;
    unique case (mode_q)
      ModeRotL, ModeRotR: begin
        if (mode_q == ModeRotL) begin
          pat_step = {pat_q[WIDTH-2:0], pat_q[WIDTH-1]};
        end else begin
          pat_step = {pat_q[0], pat_q[WIDTH-1:1]};
        end
        if (nsteps_q == PosLast) begin
          nsteps_step = '0;
          wrap_step   = 1'b1;
        end else begin
          nsteps_step = nsteps_q + PosW'(1);
        end
      end
      ModeBounce: begin
        // Position is the source of truth; the pattern is always its one-hot.
        if (dir_q == DirUp) begin
          pos_step = pos_q + PosW'(1);
          if (pos_q == PosPenult) dir_step = DirDown;
        end else begin
          pos_step = pos_q - PosW'(1);
          if (pos_q == PosW'(1)) begin
            dir_step  = DirUp;
            wrap_step = 1'b1;
          end
        end
        pat_step = OneHot0 << pos_step;
      end
      ModeCount: begin
        pat_step  = pat_q + WIDTH'(1);
        wrap_step = &pat_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      pat_q    <= INIT;
      pos_q    <= '0;
      nsteps_q <= '0;
      dir_q    <= DirUp;
      mode_q   <= ModeRotL;
      step_q   <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      step_q <= 1'b0;
      wrap_q <= 1'b0;
      if (mode != mode_q) begin
        // Mode switch restarts from INIT regardless of enable.
        mode_q   <= mode;
        pat_q    <= INIT;
        pos_q    <= '0;
        nsteps_q <= '0;
        dir_q    <= DirUp;
        cnt_q    <= '0;
      end else if (load) begin
        pat_q    <= load_val;
        pos_q    <= '0;
        nsteps_q <= '0;
        dir_q    <= DirUp;
        cnt_q    <= '0;
      end else if (enable) begin
        if (tick) begin
          cnt_q    <= '0;
          pat_q    <= pat_step;
          pos_q    <= pos_step;
          nsteps_q <= nsteps_step;
          dir_q    <= dir_step;
          step_q   <= 1'b1;
          wrap_q   <= wrap_step;
        end else begin
          cnt_q <= cnt_q + PRESCALE_W'(1);
        end
      end
    end
  end

  assign led     = ACTIVE_LOW ? ~pat_q : pat_q;
  assign step    = step_q;
  assign wrap    = wrap_q;
  assign cnt_out = cnt_q;

endmodule
